// File: rtl/fft_out_scheduler.sv
// FFT output-stage sequencer: requests each bit-reversed sample and streams it
// to the UART as Re then Im, MSB first. Optional sync header via FFT_SYNC_HEADER_EN.
module fft_out_scheduler #(
  parameter int bit_width = 24,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_rdy_i,
  output logic                 start_o,
  output logic                 en_out_o,
  input  logic                 valid_i,
  input  logic [bit_width-1:0] Re_i,
  input  logic [bit_width-1:0] Im_i,
  input  logic                 tx_busy_i,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 overrun_o
);

  localparam int BYTES  = bit_width / 8;
  localparam int NBYTES = 2 * BYTES;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW     = 2 * bit_width;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    REQ    = 3'd2,
    WAIT_V = 3'd3,
    SEND   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [SIZE-1:0]   sample_cnt_reg;
  logic [BCW-1:0]    byte_cnt_reg;
  logic [SW-1:0]     shift_reg;
  logic [7:0]        data_hold_reg;
  logic              overrun_reg;

  logic              clr_sample, inc_sample, latch_sample, inc_byte, do_shift;
  logic [7:0]        send_byte;
  logic              last_byte, last_sample;

`ifdef FFT_SYNC_HEADER_EN
  logic              hdr_phase_reg, hdr_idx_reg;
  logic              hdr_set, hdr_adv, hdr_clr;

  // Header bytes take priority over the sample shifter while the phase flag is up.
  always_comb begin
    send_byte = shift_reg[SW-1 -: 8];
    if (hdr_phase_reg) send_byte = hdr_idx_reg ? 8'h55 : 8'hAA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_phase_reg <= 1'b0;
      hdr_idx_reg   <= 1'b0;
    end else if (hdr_set) begin
      hdr_phase_reg <= 1'b1;
      hdr_idx_reg   <= 1'b0;
    end else if (hdr_adv) begin
      hdr_idx_reg   <= 1'b1;
    end else if (hdr_clr) begin
      hdr_phase_reg <= 1'b0;
      hdr_idx_reg   <= 1'b0;
    end
  end
`else
  always_comb send_byte = shift_reg[SW-1 -: 8];
`endif

  assign last_byte   = (byte_cnt_reg == BCW'(NBYTES - 1));
  assign last_sample = (sample_cnt_reg == SIZE'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    start_o      = 1'b0;
    en_out_o     = 1'b0;
    tx_start_o   = 1'b0;
    frame_done_o = 1'b0;
    clr_sample   = 1'b0;
    inc_sample   = 1'b0;
    latch_sample = 1'b0;
    inc_byte     = 1'b0;
    do_shift     = 1'b0;
`ifdef FFT_SYNC_HEADER_EN
    hdr_set      = 1'b0;
    hdr_adv      = 1'b0;
    hdr_clr      = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (frame_rdy_i) state_next = START;
      end
      START: begin
        start_o    = 1'b1;
        clr_sample = 1'b1;
`ifdef FFT_SYNC_HEADER_EN
        hdr_set    = 1'b1;
        state_next = SEND;
`else
        state_next = REQ;
`endif
      end
      REQ: begin
        en_out_o   = 1'b1;
        state_next = WAIT_V;
      end
      WAIT_V: begin
        if (valid_i) begin
          latch_sample = 1'b1;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
`ifdef FFT_SYNC_HEADER_EN
        if (hdr_phase_reg) begin
          if (!hdr_idx_reg) begin
            hdr_adv    = 1'b1;
            state_next = SEND;
          end else begin
            hdr_clr    = 1'b1;
            state_next = REQ;
          end
        end else begin
`else
        begin
`endif
          do_shift = 1'b1;
          if (!last_byte) begin
            inc_byte   = 1'b1;
            state_next = SEND;
          end else if (!last_sample) begin
            inc_sample = 1'b1;
            state_next = REQ;
          end else begin
            frame_done_o = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The hold register keeps the byte steady between handshakes; the live byte
  // is presented combinationally in the cycle that carries tx_start_o.
  always_comb begin
    tx_data_o = data_hold_reg;
    if (tx_start_o) tx_data_o = send_byte;
  end

  assign busy_o    = (state_reg != IDLE);
  assign overrun_o = overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_reg <= '0;
      byte_cnt_reg   <= '0;
      shift_reg      <= '0;
      data_hold_reg  <= 8'h00;
      overrun_reg    <= 1'b0;
    end else begin
      if (clr_sample)      sample_cnt_reg <= '0;
      else if (inc_sample) sample_cnt_reg <= sample_cnt_reg + 1'b1;

      if (latch_sample) begin
        shift_reg    <= {Re_i, Im_i};
        byte_cnt_reg <= '0;
      end else if (do_shift) begin
        shift_reg <= shift_reg << 8;
        if (inc_byte) byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end

      if (tx_start_o) data_hold_reg <= send_byte;

      if (frame_rdy_i && (state_reg != IDLE)) overrun_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_out_scheduler.sv
// Self-checking bench for fft_out_scheduler: random frames checked against a
// byte-stream model built directly from the per-sample Re/Im values.
module tb_fft_out_scheduler;
  localparam int BW    = 24;
  localparam int N     = 16;
  localparam int SIZE  = 4;
  localparam int BYTES = BW / 8;

  logic          clk;
  logic          rst_n;
  logic          frame_rdy_i;
  logic          start_o;
  logic          en_out_o;
  logic          valid_i;
  logic [BW-1:0] Re_i;
  logic [BW-1:0] Im_i;
  logic          tx_busy_i;
  logic          tx_start_o;
  logic [7:0]    tx_data_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          overrun_o;

  fft_out_scheduler #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_rdy_i  (frame_rdy_i),
    .start_o      (start_o),
    .en_out_o     (en_out_o),
    .valid_i      (valid_i),
    .Re_i         (Re_i),
    .Im_i         (Im_i),
    .tx_busy_i    (tx_busy_i),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [BW-1:0] re_arr [N];
  logic [BW-1:0] im_arr [N];
  logic [7:0]    got_q [$];
  logic [7:0]    exp_q [$];

  int   start_cnt, done_cnt, busy_viol, stab_viol, pulse_viol;
  int   req_idx, lat_left, busy_left, busy_len;
  bit   awaiting, stray_en, start_seen, en_seen;
  logic [7:0] last_data;
  logic prev_start, prev_txs, prev_done, prev_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records issued bytes and protocol violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      start_seen = 1'b0;
      en_seen    = 1'b0;
      last_data  = 8'h00;
      prev_start = 1'b0;
      prev_txs   = 1'b0;
      prev_done  = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (tx_start_o) begin
        got_q.push_back(tx_data_o);
        if (tx_busy_i) busy_viol++;
        last_data = tx_data_o;
      end else if (tx_data_o !== last_data) begin
        stab_viol++;
      end
      if (start_o) start_cnt++;
      if (frame_done_o) done_cnt++;
      if ((start_o && prev_start) || (tx_start_o && prev_txs) ||
          (frame_done_o && prev_done) || (en_out_o && prev_en)) pulse_viol++;
      prev_start = start_o;
      prev_txs   = tx_start_o;
      prev_done  = frame_done_o;
      prev_en    = en_out_o;
      start_seen = tx_start_o;
      en_seen    = en_out_o;
    end
  end

  // UART busy model and output-stage model (random latency, optional stray valids).
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_left = 0;
      tx_busy_i = 1'b0;
      lat_left  = 0;
      req_idx   = 0;
      awaiting  = 1'b0;
      valid_i   = 1'b0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (start_seen) busy_left = busy_len;
      tx_busy_i = (busy_left > 0);
      valid_i = 1'b0;
      Re_i = BW'($urandom);
      Im_i = BW'($urandom);
      if (en_seen) begin
        lat_left = $urandom_range(1, 4);
        awaiting = 1'b1;
      end
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          valid_i  = 1'b1;
          Re_i     = re_arr[req_idx % N];
          Im_i     = im_arr[req_idx % N];
          req_idx++;
          awaiting = 1'b0;
        end
      end else if (stray_en && !awaiting && $urandom_range(0, 2) == 0) begin
        valid_i = 1'b1;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk(tag, {18'd0, start_o, en_out_o, tx_start_o, tx_data_o, busy_o, frame_done_o, overrun_o}, 32'd0);
  endtask

  task automatic run_frame(input string tag, input int blen, input bit stray,
                           input int ovr_at, input int rst_at);
    logic [BW-1:0] v;
    int cycles, mism;
    bit fired;
    re_arr[0] = 24'h123456;
    im_arr[0] = 24'hFEDCBA;
    for (int i = 1; i < N; i++) begin
      re_arr[i] = BW'($urandom);
      im_arr[i] = BW'($urandom);
    end
    exp_q.delete();
`ifdef FFT_SYNC_HEADER_EN
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
`endif
    for (int s = 0; s < N; s++) begin
      v = re_arr[s];
      for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
      v = im_arr[s];
      for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
    end
    @(negedge clk);
    busy_len = blen;
    stray_en = stray;
    req_idx  = 0;
    got_q.delete();
    start_cnt = 0; done_cnt = 0; busy_viol = 0; stab_viol = 0; pulse_viol = 0;
    frame_rdy_i = 1'b1;
    @(negedge clk);
    frame_rdy_i = 1'b0;
    chk({tag, "_start_o"}, start_o, 1);
    chk({tag, "_busy_o"}, busy_o, 1);
`ifndef FFT_SYNC_HEADER_EN
    @(negedge clk);
    chk({tag, "_en_out_o"}, en_out_o, 1);
`endif
    cycles = 0;
    fired  = 1'b0;
    while (done_cnt == 0 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (frame_rdy_i) frame_rdy_i = 1'b0;
      if (ovr_at >= 0 && !fired && req_idx == ovr_at) begin
        frame_rdy_i = 1'b1;
        fired = 1'b1;
      end
      if (rst_at >= 0 && got_q.size() >= rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async_zero"});
        repeat (3) @(negedge clk);
        check_zero({tag, "_held_zero"});
        rst_n = 1'b1;
        $display("%s: reset after %0d bytes", tag, got_q.size());
        return;
      end
    end
    chk({tag, "_frame_done_cnt"}, done_cnt, 1);
    @(negedge clk);
    chk({tag, "_busy_fall"}, busy_o, 0);
    chk({tag, "_byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_stream_mismatches"}, mism, 0);
    chk({tag, "_start_cnt"}, start_cnt, 1);
    chk({tag, "_tx_while_busy"}, busy_viol, 0);
    chk({tag, "_data_stability"}, stab_viol, 0);
    chk({tag, "_pulse_width"}, pulse_viol, 0);
    $display("%s: %0d bytes, first %02h, %0d cycles", tag, got_q.size(),
             (got_q.size() > 0) ? got_q[0] : 8'h00, cycles);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_rdy_i = 1'b0;
    valid_i = 1'b0;
    tx_busy_i = 1'b0;
    Re_i = '0;
    Im_i = '0;
    busy_len = 0;
    stray_en = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");

    run_frame("basic", 0, 1'b0, -1, -1);
    chk("basic_overrun_clear", overrun_o, 0);
    run_frame("backpressure", 50, 1'b0, -1, -1);
    run_frame("stray_valid", 0, 1'b1, -1, -1);
    run_frame("overrun", 0, 1'b0, 5, -1);
    chk("overrun_sticky", overrun_o, 1);
    repeat (5) @(negedge clk);
    chk("overrun_still_set", overrun_o, 1);
    run_frame("reset_mid", 0, 1'b0, -1, 40);
    chk("overrun_cleared_by_reset", overrun_o, 0);
    run_frame("after_reset", 0, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
